mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped interval timer that sits as a responder on the processor data bus, alongside the memory map.
- The processor writes and reads the timer registers using the existing addr / write-data / we / read-data bus.
- Provides a prescaled down-counter with one-shot or auto-reload modes, a sticky expiry flag and a level interrupt output.
- The system top muxes `dout` into the processor read data whenever `sel` is high.

Parameters:
- BASE_ADDR, 16'hFF10, word address of register 0. Must be 8-aligned (bits [2:0] = 0).
- PRESCALE, 4, clocks per count tick. Legal range is 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  16  bus word address from the processor.
- din  input  16  bus write data from the processor.
- we  input  1  bus write enable, sampled at the rising edge of clk.
- dout  output  16  read data, combinational from addr and register state. It is 0 when `sel` = 0.
- sel  output  1  high when addr[15:3] == BASE_ADDR[15:3].
- irq  output  1  interrupt, equal to STATUS.expired & CTRL.irq_en.
- cap_in  input  1  asynchronous capture strobe. Ignored unless TIMER_CAPTURE_EN is defined.

Behaviour:
- Register map by addr[2:0]:
  - 0 = CTRL (RW): bit0 enable, bit1 auto_reload, bit2 irq_en. Other bits read 0.
  - 1 = LOAD (RW, 16 bits).
  - 2 = COUNT (RW). A read returns the live count; a write loads the count.
  - 3 = STATUS: bit0 expired, bit1 captured. Writing 1 to a bit clears it.
  - 4 = CAPTURE (RO).
  - 5..7 read 0; writes are ignored.
- Writes take effect at the clk edge where we=1 and sel=1. Reads have zero latency (combinational).
- Reset (reset=0, asynchronous):
  - CTRL, LOAD, COUNT, STATUS, CAPTURE and the prescaler are 0.
  - irq=0. dout and sel follow addr.
  - Reset asserted mid-count aborts the count immediately.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1 and wraps to 0.
  - `tick` is asserted in the cycle where prescaler == PRESCALE-1.
  - The prescaler holds its value while enable=0.
  - A CTRL write that changes enable from 0 to 1 clears the prescaler to 0.
- On a tick:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: expired <= 1. Then, if auto_reload=1, COUNT <= LOAD. Otherwise enable <= 0 (one-shot) and COUNT stays 0.
- Period between expiries in auto-reload mode is (LOAD+1)*PRESCALE clocks.
- First expiry occurs (COUNT_at_enable+1)*PRESCALE clocks after the enabling write edge.
- Simultaneous events:
  - A bus write to COUNT in a tick cycle wins over the decrement/reload; the prescaler still advances.
  - STATUS write-1-to-clear in the same cycle as a new expiry: the set wins and expired stays 1.
  - A CTRL write clearing enable in a tick cycle: the write wins; no decrement and no expiry that cycle.
  - A one-shot auto-clear of enable in the same cycle as a CTRL write: the CTRL write value wins.
- LOAD writes do not affect COUNT until the next reload.
- COUNT never wraps below 0.

Optional Feature:
- Macro: TIMER_CAPTURE_EN.
- Defined:
  - cap_in passes through a 2-flop synchronizer followed by a rising-edge detect.
  - On a detected edge, CAPTURE <= current COUNT (the pre-tick value) and STATUS.captured <= 1.
  - Captured uses the same set-wins-over-clear rule as expired.
  - Edge-to-latch delay is 3 clocks from the first clk edge that sees cap_in high.
- Not defined:
  - cap_in is unused. CAPTURE reads 0, STATUS bit1 reads 0, and no synchronizer flops are built.

Test Plan:
- Reset check: pulse reset low mid-run with COUNT=5 and enable=1 -> COUNT, CTRL and STATUS read 0 and irq=0 immediately, without waiting for a clock edge.
- One-shot (PRESCALE=4): write COUNT=3, then CTRL=3'b101 -> expired=1 and irq=1 exactly 16 clocks after the CTRL write edge. Enable then reads 0, COUNT stays 0 and no further expiry occurs over 100 clocks.
- Auto-reload: LOAD=2, COUNT=2, CTRL=3'b111 -> expiries every 12 clocks. Write STATUS=1 between expiries -> irq drops the next cycle and reasserts at the next expiry.
- Collisions:
  - Write STATUS=1 in the expiry cycle -> expired remains 1.
  - Write COUNT=9 in a tick cycle -> COUNT reads 9, not a decremented value.
- Decode: addr=BASE_ADDR+8 and addr=BASE_ADDR-1 with we=1 -> sel=0, dout=0 and no register changes. addr=BASE_ADDR+6 -> sel=1 and dout=0.
- Capture (macro defined): with COUNT decrementing from 20, raise cap_in -> CAPTURE holds COUNT as sampled 3 clocks later and STATUS=2'b10. Without the macro -> CAPTURE=0 and STATUS bit1=0.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: bus-mapped prescaled down-counter (one-shot / auto-reload), sticky expiry flag, level irq.
// Define TIMER_CAPTURE_EN to build the cap_in synchronizer and the CAPTURE register.

module mmio_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF10,
   parameter int unsigned PRESCALE  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [15:0] din,
   input  logic        we,
   output logic [15:0] dout,
   output logic        sel,
   output logic        irq,
   input  logic        cap_in
);

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;
   localparam logic [DW-1:0] PRESC_MAX = DW'(PRESCALE - 1);

   localparam logic [AW-1:0] REG_CTRL    = AW'(0);
   localparam logic [AW-1:0] REG_LOAD    = AW'(1);
   localparam logic [AW-1:0] REG_COUNT   = AW'(2);
   localparam logic [AW-1:0] REG_STATUS  = AW'(3);
   localparam logic [AW-1:0] REG_CAPTURE = AW'(4);

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic enable;
   } ctrl_t;

   ctrl_t         ctrl_q, ctrl_d;
   logic [DW-1:0] load_q, load_d;
   logic [DW-1:0] count_q, count_d;
   logic [DW-1:0] presc_q, presc_d;
   logic          expired_q, expired_d;

   logic          wr_c;
   logic          wr_ctrl_c, wr_load_c, wr_count_c, wr_status_c;
   logic          tick_c, tick_eff_c, expire_c;
   logic [DW-1:0] capture_rd_c;
   logic          captured_rd_c;

   assign sel = (addr[DW-1:AW] == BASE_ADDR[DW-1:AW]);

   // Bus write strobes, one per writable register
   always_comb begin
      wr_c        = we & sel;
      wr_ctrl_c   = wr_c & (addr[AW-1:0] == REG_CTRL);
      wr_load_c   = wr_c & (addr[AW-1:0] == REG_LOAD);
      wr_count_c  = wr_c & (addr[AW-1:0] == REG_COUNT);
      wr_status_c = wr_c & (addr[AW-1:0] == REG_STATUS);
   end

   // Prescaler, counter and status next-state; bus writes are applied last so they win
   always_comb begin
      ctrl_d     = ctrl_q;
      load_d     = load_q;
      count_d    = count_q;
      presc_d    = presc_q;
      expired_d  = expired_q;
      expire_c   = 1'b0;

      tick_c     = ctrl_q.enable & (presc_q == PRESC_MAX);
      // a CTRL write that clears enable suppresses this cycle's tick
      tick_eff_c = tick_c & ~(wr_ctrl_c & ~din[0]);

      if (ctrl_q.enable) begin
         presc_d = tick_c ? '0 : presc_q + DW'(1);
      end

      if (tick_eff_c) begin
         if (count_q != '0) begin
            count_d = count_q - DW'(1);
         end else begin
            expire_c = 1'b1;
            if (ctrl_q.auto_reload) begin
               count_d = load_q;
            end else begin
               ctrl_d.enable = 1'b0;
            end
         end
      end

      if (wr_ctrl_c) begin
         ctrl_d = ctrl_t'(din[2:0]);
         if (!ctrl_q.enable && din[0]) begin
            presc_d = '0;
         end
      end
      if (wr_load_c) begin
         load_d = din;
      end
      if (wr_count_c) begin
         count_d = din;
      end
      if (wr_status_c && din[0]) begin
         expired_d = 1'b0;
      end
      if (expire_c) begin
         expired_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q    <= '0;
         load_q    <= '0;
         count_q   <= '0;
         presc_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
      end
   end

`ifdef TIMER_CAPTURE_EN
   logic          cap_meta_q, cap_meta_d;
   logic          cap_sync_q, cap_sync_d;
   logic          cap_prev_q, cap_prev_d;
   logic          cap_pulse_q, cap_pulse_d;
   logic          captured_q, captured_d;
   logic [DW-1:0] capture_q, capture_d;

   // Two-flop synchronizer, registered rising-edge pulse, then latch the pre-tick count
   always_comb begin
      cap_meta_d  = cap_in;
      cap_sync_d  = cap_meta_q;
      cap_prev_d  = cap_sync_q;
      cap_pulse_d = cap_sync_q & ~cap_prev_q;
      capture_d   = capture_q;
      captured_d  = captured_q;
      if (wr_status_c && din[1]) begin
         captured_d = 1'b0;
      end
      if (cap_pulse_q) begin
         capture_d  = count_q;
         captured_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_meta_q  <= 1'b0;
         cap_sync_q  <= 1'b0;
         cap_prev_q  <= 1'b0;
         cap_pulse_q <= 1'b0;
         captured_q  <= 1'b0;
         capture_q   <= '0;
      end else begin
         cap_meta_q  <= cap_meta_d;
         cap_sync_q  <= cap_sync_d;
         cap_prev_q  <= cap_prev_d;
         cap_pulse_q <= cap_pulse_d;
         captured_q  <= captured_d;
         capture_q   <= capture_d;
      end
   end

   assign capture_rd_c  = capture_q;
   assign captured_rd_c = captured_q;
`else
   logic unused_cap_in;

   assign unused_cap_in = cap_in;
   assign capture_rd_c  = '0;
   assign captured_rd_c = 1'b0;
`endif

   // Zero-latency read mux
   always_comb begin
      dout = '0;
      if (sel) begin
         case (addr[AW-1:0])
            REG_CTRL:    dout = DW'(ctrl_q);
            REG_LOAD:    dout = load_q;
            REG_COUNT:   dout = count_q;
            REG_STATUS:  dout = DW'({captured_rd_c, expired_q});
            REG_CAPTURE: dout = capture_rd_c;
            default:     dout = '0;
         endcase
      end
   end

   assign irq = expired_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed scenarios plus randomized bus traffic checked against a cycle-level
// reference model of the register map, prescaler and capture path.

module tb_mmio_timer;

   localparam logic [15:0] BASE      = 16'hFF10;
   localparam int unsigned PRESCALE  = 4;
   localparam logic [15:0] A_CTRL    = BASE;
   localparam logic [15:0] A_LOAD    = BASE + 16'd1;
   localparam logic [15:0] A_COUNT   = BASE + 16'd2;
   localparam logic [15:0] A_STATUS  = BASE + 16'd3;
   localparam logic [15:0] A_CAPTURE = BASE + 16'd4;

   logic        clk    = 1'b0;
   logic        reset  = 1'b0;
   logic [15:0] addr   = '0;
   logic [15:0] din    = '0;
   logic        we     = 1'b0;
   logic        cap_in = 1'b0;
   logic [15:0] dout;
   logic        sel;
   logic        irq;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(PRESCALE)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .din    (din),
      .we     (we),
      .dout   (dout),
      .sel    (sel),
      .irq    (irq),
      .cap_in (cap_in)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic        m_en = 1'b0, m_ar = 1'b0, m_ie = 1'b0, m_exp = 1'b0, m_capd = 1'b0;
   logic [15:0] m_load = '0, m_cnt = '0, m_cap = '0;
   int          m_ph = 0;           // clocks elapsed in the current tick interval
   logic [3:0]  m_hist = '0;        // m_hist[j]: cap_in as seen j+1 edges ago

   function automatic logic [15:0] m_read(input logic [15:0] a);
      if (a[15:3] != BASE[15:3]) return 16'd0;
      case (a[2:0])
         3'd0:    return {13'd0, m_ie, m_ar, m_en};
         3'd1:    return m_load;
         3'd2:    return m_cnt;
         3'd3:    return {14'd0, m_capd, m_exp};
         3'd4:    return m_cap;
         default: return 16'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_en = 1'b0; m_ar = 1'b0; m_ie = 1'b0; m_exp = 1'b0; m_capd = 1'b0;
      m_load = '0; m_cnt = '0; m_cap = '0; m_ph = 0; m_hist = '0;
   endtask

   task automatic model_step();
      logic        tick, hit, ctrl_wr, set_exp, set_cap, n_en;
      logic [2:0]  r;
      logic [15:0] n_cnt;
      int          n_ph;
      tick    = m_en && (m_ph == int'(PRESCALE) - 1);
      hit     = we && (addr[15:3] == BASE[15:3]);
      r       = addr[2:0];
      ctrl_wr = hit && (r == 3'd0);
      n_en    = m_en;
      n_cnt   = m_cnt;
      set_exp = 1'b0;
      set_cap = 1'b0;
      n_ph    = m_en ? (m_ph + 1) % int'(PRESCALE) : m_ph;
      if (tick && !(ctrl_wr && !din[0])) begin
         if (m_cnt != 16'd0) n_cnt = m_cnt - 16'd1;
         else begin
            set_exp = 1'b1;
            if (m_ar) n_cnt = m_load;
            else      n_en  = 1'b0;
         end
      end
`ifdef TIMER_CAPTURE_EN
      if (m_hist[2] && !m_hist[3]) begin
         m_cap   = m_cnt;
         set_cap = 1'b1;
      end
`endif
      m_hist = {m_hist[2:0], cap_in};
      if (ctrl_wr) begin
         if (!m_en && din[0]) n_ph = 0;
         n_en = din[0];
         m_ar = din[1];
         m_ie = din[2];
      end
      if (hit && r == 3'd1) m_load = din;
      if (hit && r == 3'd2) n_cnt = din;
      if (hit && r == 3'd3) begin
         if (din[0]) m_exp  = 1'b0;
         if (din[1]) m_capd = 1'b0;
      end
      if (set_exp) m_exp  = 1'b1;
      if (set_cap) m_capd = 1'b1;
      m_en  = n_en;
      m_cnt = n_cnt;
      m_ph  = n_ph;
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One bus cycle: drive at the falling edge, settle, leave it for the next rising edge
   task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
      @(negedge clk);
      addr = a;
      din  = d;
      we   = w;
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      we    = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_irq(input int limit, output int t);
      t = -1;
      for (int i = 0; i < limit; i++) begin
         drive(A_STATUS, 16'd0, 1'b0);
         if (irq) begin
            t = cyc;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: no finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, t1, t2, bad;
      logic [15:0] a, d;
      int r;

      // Reset state
      drive(A_CTRL, 16'd0, 1'b0);   check_eq("rst_ctrl", dout, 16'd0);
      drive(A_COUNT, 16'd0, 1'b0);  check_eq("rst_count", dout, 16'd0);
      drive(A_STATUS, 16'd0, 1'b0); check_eq("rst_status", dout, 16'd0);
      check_eq("rst_irq", 16'(irq), 16'd0);
      check_eq("rst_sel", 16'(sel), 16'd1);
      reset = 1'b1;

      // Asynchronous reset in the middle of a count
      drive(A_COUNT, 16'd5, 1'b1);
      drive(A_CTRL, 16'd1, 1'b1);
      drive(A_COUNT, 16'd0, 1'b0);  check_eq("pre_rst_count", dout, 16'd5);
      reset = 1'b0;
      #1;              check_eq("async_rst_count", dout, 16'd0);
      addr = A_CTRL;   #1; check_eq("async_rst_ctrl", dout, 16'd0);
      addr = A_STATUS; #1; check_eq("async_rst_status", dout, 16'd0);
      check_eq("async_rst_irq", 16'(irq), 16'd0);
      drive(A_CTRL, 16'd0, 1'b0);
      reset = 1'b1;

      // One-shot: COUNT=3, enable with irq_en
      drive(A_COUNT, 16'd3, 1'b1);
      drive(A_CTRL, 16'd5, 1'b1);
      t0 = cyc;
      wait_irq(40, t1);
      check_eq("oneshot_latency", 16'(t1 - t0 - 1), 16'd16);
      check_eq("oneshot_status", dout, 16'd1);
      drive(A_CTRL, 16'd0, 1'b0);   check_eq("oneshot_ctrl", dout, 16'd4);
      drive(A_COUNT, 16'd0, 1'b0);  check_eq("oneshot_count", dout, 16'd0);
      drive(A_STATUS, 16'd1, 1'b1);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         drive(A_STATUS, 16'd0, 1'b0);
         if (irq || dout[0]) bad++;
      end
      check_eq("oneshot_no_rearm", 16'(bad), 16'd0);

      // Auto-reload: LOAD=2, COUNT=2 -> expiry every 12 clocks
      do_reset();
      drive(A_LOAD, 16'd2, 1'b1);
      drive(A_COUNT, 16'd2, 1'b1);
      drive(A_CTRL, 16'd7, 1'b1);
      t0 = cyc;
      wait_irq(40, t1);
      check_eq("reload_first", 16'(t1 - t0 - 1), 16'd12);
      drive(A_STATUS, 16'd1, 1'b1);
      drive(A_STATUS, 16'd0, 1'b0); check_eq("w1c_irq_drop", 16'(irq), 16'd0);
      wait_irq(40, t2);
      check_eq("reload_period", 16'(t2 - t1), 16'd12);

      // Clear racing a new expiry: the set wins
      drive(A_STATUS, 16'd1, 1'b1);
      while (cyc < t2 + 10) drive(A_STATUS, 16'd0, 1'b0);
      drive(A_STATUS, 16'd1, 1'b1); check_eq("pre_expiry_status", dout, 16'd0);
      drive(A_STATUS, 16'd0, 1'b0); check_eq("w1c_vs_set", dout, 16'd1);
      check_eq("w1c_vs_set_irq", 16'(irq), 16'd1);

      // COUNT write in a tick cycle beats the decrement; prescaler keeps its phase
      drive(A_COUNT, 16'd0, 1'b0);
      drive(A_COUNT, 16'd0, 1'b0);
      drive(A_COUNT, 16'd9, 1'b1);  check_eq("pre_tick_count", dout, 16'd2);
      drive(A_COUNT, 16'd0, 1'b0);  check_eq("tick_write_count", dout, 16'd9);
      drive(A_COUNT, 16'd0, 1'b0);
      drive(A_COUNT, 16'd0, 1'b0);
      drive(A_COUNT, 16'd0, 1'b0);  check_eq("post_write_hold", dout, 16'd9);
      drive(A_COUNT, 16'd0, 1'b0);  check_eq("post_write_dec", dout, 16'd8);

      // Address decode
      drive(BASE + 16'd8, 16'd0, 1'b1);
      check_eq("dec_above_sel", 16'(sel), 16'd0);
      check_eq("dec_above_dout", dout, 16'd0);
      drive(BASE - 16'd1, 16'd0, 1'b1);
      check_eq("dec_below_sel", 16'(sel), 16'd0);
      check_eq("dec_below_dout", dout, 16'd0);
      drive(A_CTRL, 16'd0, 1'b0);   check_eq("dec_no_write", dout, 16'd7);
      drive(BASE + 16'd6, 16'hFFFF, 1'b1);
      check_eq("dec_hole_sel", 16'(sel), 16'd1);
      check_eq("dec_hole_dout", dout, 16'd0);

      // Capture while counting down from 20
      do_reset();
      drive(A_COUNT, 16'd20, 1'b1);
      drive(A_CTRL, 16'd1, 1'b1);
      repeat (6) drive(A_COUNT, 16'd0, 1'b0);
      cap_in = 1'b1;
      repeat (3) drive(A_COUNT, 16'd0, 1'b0);
      drive(A_CAPTURE, 16'd0, 1'b0);
`ifdef TIMER_CAPTURE_EN
      check_eq("capture_value", dout, 16'd18);
      drive(A_STATUS, 16'd0, 1'b0); check_eq("capture_status", dout, 16'd2);
`else
      check_eq("capture_value", dout, 16'd0);
      drive(A_STATUS, 16'd0, 1'b0); check_eq("capture_status", dout, 16'd0);
`endif
      cap_in = 1'b0;

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 249) != 0);
         if ($urandom_range(0, 15) == 0) cap_in = ~cap_in;
         r = int'($urandom_range(0, 7));
         a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'(r);
         case (r)
            0: begin
               d = 16'($urandom_range(0, 7));
               if ($urandom_range(0, 2) != 0) d[0] = 1'b1;
            end
            1, 2:    d = 16'($urandom_range(0, 5));
            3:       d = 16'($urandom_range(0, 3));
            default: d = 16'($urandom);
         endcase
         addr = a;
         din  = d;
         we   = ($urandom_range(0, 5) == 0);
         cyc++;
         #1;
         check_eq("rand_sel", 16'(sel), 16'(a[15:3] == BASE[15:3]));
         check_eq("rand_dout", dout, m_read(a));
         check_eq("rand_irq", 16'(irq), 16'(m_exp & m_ie));
      end
      reset = 1'b1;
      we    = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
